// File: rtl/execute_hazard_controller.sv
// Execute-stage hazard sequencer: load-use stalls, branch flushes and memory freeze.
// Optional HAZARD_PERF_CNT_EN adds 32-bit stall/flush cycle counters.
module execute_hazard_controller #(
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int LOAD_STALL_CYCLES = 2,
  parameter int FLUSH_CYCLES      = 1,
  parameter int MEM_TIMEOUT       = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] id_reg_a_addr_in,
  input  logic [REG_ADDR_WIDTH-1:0] id_reg_b_addr_in,
  input  logic                      id_reg_a_used_in,
  input  logic                      id_reg_b_used_in,
  input  logic                      ex_mem_rd_en_in,
  input  logic [REG_ADDR_WIDTH-1:0] ex_reg_wr_addr_in,
  input  logic                      select_new_pc_in,
  input  logic                      mem_access_in,
  input  logic                      mem_busy_in,
  output logic                      pc_stall_out,
  output logic                      if_id_stall_out,
  output logic                      id_ex_bubble_out,
  output logic                      id_ex_stall_out,
  output logic                      ex_mem_stall_out,
  output logic                      if_id_flush_out,
  output logic                      id_ex_flush_out,
  output logic                      mem_timeout_out,
  output logic [1:0]                state_out,
  output logic [31:0]               stall_cycles_out,
  output logic [31:0]               flush_cycles_out
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2
  } state_t;

  localparam logic [2:0]  LS_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0]  FL_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TMO_LAST  = 16'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] tmo_cnt_q;
  logic        mem_timeout_q;

  logic hazard;
  logic freeze;
  logic pc_stall_c, if_id_stall_c, bubble_c, id_ex_stall_c, ex_mem_stall_c;
  logic if_id_flush_c, id_ex_flush_c;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  function automatic logic load_use(
    input logic                      ld,
    input logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input logic [REG_ADDR_WIDTH-1:0] rs_a,
    input logic                      use_a,
    input logic [REG_ADDR_WIDTH-1:0] rs_b,
    input logic                      use_b
  );
    return ld && (ex_rd != '0) &&
           ((use_a && (rs_a == ex_rd)) || (use_b && (rs_b == ex_rd)));
  endfunction

  assign hazard = load_use(ex_mem_rd_en_in, ex_reg_wr_addr_in,
                           id_reg_a_addr_in, id_reg_a_used_in,
                           id_reg_b_addr_in, id_reg_b_used_in);
  assign freeze = mem_access_in & mem_busy_in;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    bubble_c       = 1'b0;
    id_ex_stall_c  = 1'b0;
    ex_mem_stall_c = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_flush_c  = 1'b0;

    if (freeze) begin
      pc_stall_c     = 1'b1;
      if_id_stall_c  = 1'b1;
      id_ex_stall_c  = 1'b1;
      ex_mem_stall_c = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (select_new_pc_in) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = ST_FLUSH;
              cnt_d   = FL_RELOAD;
            end
          end else if (hazard) begin
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            bubble_c      = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = ST_LOAD_STALL;
              cnt_d   = LS_RELOAD;
            end
          end
        end
        ST_LOAD_STALL: begin
          if (select_new_pc_in) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = ST_FLUSH;
              cnt_d   = FL_RELOAD;
            end else begin
              state_d = ST_RUN;
              cnt_d   = 3'd0;
            end
          end else begin
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            bubble_c      = 1'b1;
            cnt_d         = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = ST_RUN;
          end
        end
        ST_FLUSH: begin
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
          if (select_new_pc_in) begin
            cnt_d = FL_RELOAD;
          end else begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q       <= ST_RUN;
      cnt_q         <= 3'd0;
      tmo_cnt_q     <= 16'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (freeze) begin
        if (tmo_cnt_q == TMO_LAST) begin
          mem_timeout_q <= 1'b1;
          tmo_cnt_q     <= 16'd0;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
      end else begin
        tmo_cnt_q <= 16'd0;
      end
    end
  end

  // Reset is active-high on rst_n; outputs are held quiet while it is asserted.
  assign pc_stall_out     = ~rst_n & pc_stall_c;
  assign if_id_stall_out  = ~rst_n & if_id_stall_c;
  assign id_ex_bubble_out = ~rst_n & bubble_c;
  assign id_ex_stall_out  = ~rst_n & id_ex_stall_c;
  assign ex_mem_stall_out = ~rst_n & ex_mem_stall_c;
  assign if_id_flush_out  = ~rst_n & if_id_flush_c;
  assign id_ex_flush_out  = ~rst_n & id_ex_flush_c;
  assign mem_timeout_out  = mem_timeout_q;
  assign state_out        = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_cycles_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      stall_cycles_q <= 32'd0;
      flush_cycles_q <= 32'd0;
    end else begin
      if (pc_stall_out)    stall_cycles_q <= stall_cycles_q + 32'd1;
      if (if_id_flush_out) flush_cycles_q <= flush_cycles_q + 32'd1;
    end
  end

  assign stall_cycles_out = stall_cycles_q;
  assign flush_cycles_out = flush_cycles_q;
`else
  assign stall_cycles_out = 32'd0;
  assign flush_cycles_out = 32'd0;
`endif

endmodule

// File: tb/tb_execute_hazard_controller.sv
// Directed bench for execute_hazard_controller: two instances (FLUSH_CYCLES 1 and 3).
module tb_execute_hazard_controller;

  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] STL  = 7'b1110000;  // pc, if_id stall, bubble
  localparam logic [6:0] FRZ  = 7'b1101100;  // all four stalls
  localparam logic [6:0] FLS  = 7'b0000011;  // both flushes

  logic       clk;
  logic       rst_n;
  logic [4:0] a_addr, b_addr, ex_addr;
  logic       a_used, b_used, ld, sel, macc, mbusy;

  logic       pcs0, ifs0, bub0, ids0, exs0, iff0, idf0, tmo0;
  logic [1:0] st0;
  logic [31:0] sc0, fc0;
  logic       pcs1, ifs1, bub1, ids1, exs1, iff1, idf1, tmo1;
  logic [1:0] st1;
  logic [31:0] sc1, fc1;

  int n_tests = 0;
  int n_fail  = 0;

  execute_hazard_controller #(.REG_ADDR_WIDTH(5), .LOAD_STALL_CYCLES(2),
    .FLUSH_CYCLES(1), .MEM_TIMEOUT(8)) u0 (
    .clk(clk), .rst_n(rst_n),
    .id_reg_a_addr_in(a_addr), .id_reg_b_addr_in(b_addr),
    .id_reg_a_used_in(a_used), .id_reg_b_used_in(b_used),
    .ex_mem_rd_en_in(ld), .ex_reg_wr_addr_in(ex_addr),
    .select_new_pc_in(sel), .mem_access_in(macc), .mem_busy_in(mbusy),
    .pc_stall_out(pcs0), .if_id_stall_out(ifs0), .id_ex_bubble_out(bub0),
    .id_ex_stall_out(ids0), .ex_mem_stall_out(exs0),
    .if_id_flush_out(iff0), .id_ex_flush_out(idf0),
    .mem_timeout_out(tmo0), .state_out(st0),
    .stall_cycles_out(sc0), .flush_cycles_out(fc0));

  execute_hazard_controller #(.REG_ADDR_WIDTH(5), .LOAD_STALL_CYCLES(2),
    .FLUSH_CYCLES(3), .MEM_TIMEOUT(8)) u1 (
    .clk(clk), .rst_n(rst_n),
    .id_reg_a_addr_in(a_addr), .id_reg_b_addr_in(b_addr),
    .id_reg_a_used_in(a_used), .id_reg_b_used_in(b_used),
    .ex_mem_rd_en_in(ld), .ex_reg_wr_addr_in(ex_addr),
    .select_new_pc_in(sel), .mem_access_in(macc), .mem_busy_in(mbusy),
    .pc_stall_out(pcs1), .if_id_stall_out(ifs1), .id_ex_bubble_out(bub1),
    .id_ex_stall_out(ids1), .ex_mem_stall_out(exs1),
    .if_id_flush_out(iff1), .id_ex_flush_out(idf1),
    .mem_timeout_out(tmo1), .state_out(st1),
    .stall_cycles_out(sc1), .flush_cycles_out(fc1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic [6:0] eo, input logic [1:0] es);
    chk({tag, "_u0_outs"}, {25'd0, pcs0, ifs0, bub0, ids0, exs0, iff0, idf0}, {25'd0, eo});
    chk({tag, "_u0_state"}, {30'd0, st0}, {30'd0, es});
  endtask

  task automatic chk1(input string tag, input logic [6:0] eo, input logic [1:0] es);
    chk({tag, "_u1_outs"}, {25'd0, pcs1, ifs1, bub1, ids1, exs1, iff1, idf1}, {25'd0, eo});
    chk({tag, "_u1_state"}, {30'd0, st1}, {30'd0, es});
  endtask

  task automatic drive(input logic l, input logic [4:0] ea, input logic [4:0] ra,
                       input logic ua, input logic [4:0] rb, input logic ub,
                       input logic s, input logic ma, input logic mb);
    ld = l; ex_addr = ea; a_addr = ra; a_used = ua; b_addr = rb; b_used = ub;
    sel = s; macc = ma; mbusy = mb;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hz3();
    drive(1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_sc, exp_fc;

  initial begin
    // Reset with a hazard on the inputs: everything must stay quiet.
    rst_n = 1'b1;
    hz3();
    cyc(); cyc(); #1;
    chk0("rst", NONE, 2'd0);
    chk("rst_tmo", {31'd0, tmo0}, 32'd0);
    chk("rst_perf_stall", sc0, 32'd0);
    chk("rst_perf_flush", fc0, 32'd0);

    cyc(); rst_n = 1'b0; idle(); #1;
    chk0("idle", NONE, 2'd0);

    // Load-use on source A: two bubble cycles.
    cyc(); hz3(); #1;            chk0("lu_a_c0", STL, 2'd0);
    cyc(); idle(); #1;           chk0("lu_a_c1", STL, 2'd1);
    cyc(); #1;                   chk0("lu_a_c2", NONE, 2'd0);

    // Loads to r0 and unused sources never stall.
    cyc(); drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk0("r0", NONE, 2'd0);
    cyc(); drive(1'b1, 5'd5, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    chk0("unused", NONE, 2'd0);

    // Load-use on source B.
    cyc(); drive(1'b1, 5'd5, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk0("lu_b_c0", STL, 2'd0);
    cyc(); idle(); #1;           chk0("lu_b_c1", STL, 2'd1);
    cyc(); #1;                   chk0("lu_b_c2", NONE, 2'd0);

    // Branch during load stall abandons it; u1 holds flush for 3 cycles.
    cyc(); hz3(); #1;            chk0("br_c0", STL, 2'd0); chk1("br_c0", STL, 2'd0);
    cyc(); drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); #1;
    chk0("br_c1", FLS, 2'd1); chk1("br_c1", FLS, 2'd1);
    cyc(); idle(); #1;           chk0("br_c2", NONE, 2'd0); chk1("br_c2", FLS, 2'd2);
    cyc(); hz3(); #1;            chk1("br_c3", FLS, 2'd2);
    cyc(); idle(); #1;           chk1("br_c4", NONE, 2'd0);

    // A second branch inside FLUSH reloads the count.
    cyc(); drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); #1;
    chk1("rl_c0", FLS, 2'd0);
    cyc(); #1;                   chk1("rl_c1", FLS, 2'd2);
    cyc(); idle(); #1;           chk1("rl_c2", FLS, 2'd2);
    cyc(); #1;                   chk1("rl_c3", FLS, 2'd2);
    cyc(); #1;                   chk1("rl_c4", NONE, 2'd0);

    // Freeze for 4 cycles mid load stall, then the remaining bubble.
    cyc(); hz3(); #1;            chk0("fz_c0", STL, 2'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(); drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); #1;
      chk0("fz_busy", FRZ, 2'd1);
    end
    cyc(); idle(); #1;           chk0("fz_rel", STL, 2'd1);
    cyc(); #1;                   chk0("fz_done", NONE, 2'd0);

    // Access without busy, or busy without access, is not a freeze.
    cyc(); drive(1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
    chk0("acc_only", STL, 2'd0);
    cyc(); drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); #1;
    chk0("busy_only", STL, 2'd1);
    cyc(); idle(); #1;           chk0("busy_only_done", NONE, 2'd0);

    // Branch held through freeze is flushed once memory is ready.
    cyc(); drive(1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1); #1;
    chk0("fzbr_c0", FRZ, 2'd0);
    cyc(); #1;                   chk0("fzbr_c1", FRZ, 2'd0);
    cyc(); drive(1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); #1;
    chk0("fzbr_c2", FLS, 2'd0); chk1("fzbr_c2", FLS, 2'd0);
    cyc(); idle(); #1;           chk0("fzbr_c3", NONE, 2'd0); chk1("fzbr_c3", FLS, 2'd2);
    cyc(); drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); #1;
    chk1("fzfl_c4", FRZ, 2'd2);
    cyc(); idle(); #1;           chk1("fzfl_c5", FLS, 2'd2);
    cyc(); #1;                   chk1("fzfl_c6", NONE, 2'd0);

    // Timeout: busy 20 cycles, flag rises after the 8th and stays.
    for (int k = 1; k <= 20; k++) begin
      cyc(); drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); #1;
      chk($sformatf("tmo_k%0d", k), {31'd0, tmo0}, (k >= 9) ? 32'd1 : 32'd0);
    end
    chk0("tmo_still_frozen", FRZ, 2'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(); idle(); #1;
      chk("tmo_sticky", {31'd0, tmo0}, 32'd1);
    end
    cyc(); rst_n = 1'b1; #1;
    cyc(); rst_n = 1'b0; #1;
    chk("tmo_cleared", {31'd0, tmo0}, 32'd0);

    // Reset mid-flush (u1) and mid-stall (u0).
    cyc(); drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); #1;
    chk1("rflush_c0", FLS, 2'd0);
    cyc(); rst_n = 1'b1; #1;     chk1("rflush_rst", NONE, 2'd2);
    cyc(); rst_n = 1'b0; idle(); #1;
    chk1("rflush_after", NONE, 2'd0);
    cyc(); hz3(); #1;            chk0("rstall_c0", STL, 2'd0);
    cyc(); rst_n = 1'b1; #1;     chk0("rstall_rst", NONE, 2'd1);
    cyc(); rst_n = 1'b0; idle(); #1;
    chk0("rstall_after", NONE, 2'd0);

    // Perf counters: one load-use (2 stall cycles) plus one flush.
    cyc(); hz3(); #1;
    cyc(); idle(); #1;
    cyc(); drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); #1;
    cyc(); idle(); #1;
`ifdef HAZARD_PERF_CNT_EN
    exp_sc = 32'd2; exp_fc = 32'd1;
`else
    exp_sc = 32'd0; exp_fc = 32'd0;
`endif
    chk("perf_stall", sc0, exp_sc);
    chk("perf_flush", fc0, exp_fc);
    cyc(); rst_n = 1'b1; #1;
    cyc(); rst_n = 1'b0; #1;
    chk("perf_stall_rst", sc0, 32'd0);
    chk("perf_flush_rst", fc0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
